seq_alu_core: RTL

//  Parametrised successor to the 16-bit four-unit ALU. One registered result port, a valid/ready

---
 rtl/seq_alu_pkg.sv | 49 ++++
 rtl/seq_muldiv_engine.sv | 106 ++++++++++
 rtl/seq_alu_core.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU core.
//   - Operation class and opcode encodings. ALU_FUN[3:2] selects the class and
//     ALU_FUN[1:0] selects the operation within that class.
//   - Control state encoding: IDLE / BUSY / DONE.
//   - Bit positions inside the registered flag vector.
package seq_alu_pkg;

    // Operation classes (ALU_FUN[3:2])
    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_CMP   = 2'b10;
    localparam logic [1:0] CLS_SHIFT = 2'b11;

    // Arithmetic ops
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Logic ops
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    // Compare ops; the last encoding is reserved and always yields 0
    localparam logic [1:0] OP_EQ      = 2'b00;
    localparam logic [1:0] OP_GT      = 2'b01;
    localparam logic [1:0] OP_LT      = 2'b10;
    localparam logic [1:0] OP_CMP_RSV = 2'b11;

    // Shift ops
    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    // Control states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Flag vector layout
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_DIV0  = 2;
    localparam int FLAG_W     = 3;

endpackage

// File: rtl/seq_muldiv_engine.sv
// Iterative signed multiply / restoring divide engine.
// Works on operand magnitudes, one bit per cycle for WIDTH cycles, and applies
// the sign fix-up combinationally on the final iteration so the caller can
// register the finished result on the same edge that `done` is seen.
// Ports:
//   clk, rst  clock and synchronous active-high reset (aborts any operation)
//   start     load a, b, op and begin iterating (ignored unless issued from idle)
//   op        OP_MUL or OP_DIV
//   a, b      signed operands; b must be non-zero for OP_DIV
//   done      high during the last iteration cycle; result is valid then
//   result    MUL: 2*WIDTH signed product; DIV: {remainder, quotient}
module seq_muldiv_engine
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic               busy;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_res;   // product / quotient is negative
    logic               neg_rem;   // remainder follows the sign of a
    logic [WIDTH-1:0]   operand;   // |b|: multiplicand or divisor
    // acc = {hi, lo}. MUL: hi is the running partial sum, lo the multiplier
    // bits still to consume. DIV: hi is the partial remainder, lo shifts the
    // dividend out of the top while quotient bits enter at the bottom.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // The magnitude of the most negative value is 2^(WIDTH-1), which still
    // fits when read as unsigned.
    assign mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        acc_next  = acc;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        if (is_div) begin
            // A clear top bit means no borrow: the divisor fits, keep the difference.
            if (!div_diff[WIDTH]) begin
                acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    assign quo    = neg_res ? (~acc_next[WIDTH-1:0] + 1'b1) : acc_next[WIDTH-1:0];
    assign rem    = neg_rem ? (~acc_next[2*WIDTH-1:WIDTH] + 1'b1) : acc_next[2*WIDTH-1:WIDTH];
    assign result = is_div ? {rem, quo} : (neg_res ? (~acc_next + 1'b1) : acc_next);
    assign done   = busy && (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the values from before this clock edge.
        if (rst) begin
            busy    <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (start && !busy) begin
            busy    <= 1'b1;
            cnt     <= CNT_W'(WIDTH);
            acc     <= {{WIDTH{1'b0}}, mag_a};
            operand <= mag_b;
            is_div  <= (op == OP_DIV);
            neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem <= a[WIDTH-1];
        end else if (busy) begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu_core.sv
// Sequential ALU core: accepts one operation at a time over a valid/ready
// handshake. It computes the single-cycle ops directly and hands MUL and DIV
// (with B != 0) to the iterative engine. RESULT and the flags are held in
// registers until the consumer accepts them.
// Ports:
//   CLK, RST              clock and synchronous active-high reset
//   IN_VALID / IN_READY   input handshake; IN_READY is high only in IDLE
//   A, B                  signed operands
//   ALU_FUN               {class[1:0], op[1:0]}
//   OUT_VALID / OUT_READY output handshake; OUT_VALID is high only in DONE
//   RESULT                2*WIDTH result
//   CARRY_OUT             ADD carry / SUB borrow, 0 otherwise
//   ZERO_FLAG             RESULT == 0
//   DIV0_FLAG             DIV issued with B == 0
module seq_alu_core
    import seq_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         ALU_FUN,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [2*WIDTH-1:0] RESULT,
    output logic               CARRY_OUT,
    output logic               ZERO_FLAG,
    output logic               DIV0_FLAG
);

    logic [1:0]         state;
    logic [2*WIDTH-1:0] result_q;
    logic [FLAG_W-1:0]  flags_q;

    logic [1:0]         cls;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] amt;
    logic               accept;
    logic               use_engine;

    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH-1:0]   srl_v;
    logic [WIDTH-1:0]   sll_v;
    logic [WIDTH-1:0]   sra_v;
    logic [2*WIDTH-1:0] rol_wide;

    logic [2*WIDTH-1:0] sc_result;
    logic               sc_carry;
    logic               sc_div0;

    logic               eng_done;
    logic [2*WIDTH-1:0] eng_result;

    assign cls        = ALU_FUN[3:2];
    assign op         = ALU_FUN[1:0];
    assign amt        = B[SHAMT_W-1:0];
    assign accept     = IN_VALID && IN_READY;
    // DIV by zero has a fixed answer and skips the iterative path.
    assign use_engine = (cls == CLS_ARITH) &&
                        ((op == OP_MUL) || ((op == OP_DIV) && (B != '0)));

    // Unsigned extension by one bit exposes the ADD carry and the SUB borrow.
    assign add_full = {1'b0, A} + {1'b0, B};
    assign sub_full = {1'b0, A} - {1'b0, B};
    assign srl_v    = A >> amt;
    assign sll_v    = A << amt;
    assign sra_v    = $signed(A) >>> amt;
    // Rotating left is the upper half of the doubled word shifted left.
    assign rol_wide = {A, A} << amt;

    always_comb begin
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_div0   = 1'b0;
        case (cls)
            CLS_ARITH: begin
                case (op)
                    OP_ADD: begin
                        sc_result = {{WIDTH{add_full[WIDTH-1]}}, add_full[WIDTH-1:0]};
                        sc_carry  = add_full[WIDTH];
                    end
                    OP_SUB: begin
                        sc_result = {{WIDTH{sub_full[WIDTH-1]}}, sub_full[WIDTH-1:0]};
                        sc_carry  = sub_full[WIDTH];
                    end
                    OP_MUL: sc_result = '0;
                    OP_DIV: begin
                        // Only reached with B == 0: quotient all ones, remainder A.
                        sc_result = {A, {WIDTH{1'b1}}};
                        sc_div0   = 1'b1;
                    end
                    default: sc_result = '0;
                endcase
            end
            CLS_LOGIC: begin
                case (op)
                    OP_AND:  sc_result = {{WIDTH{1'b0}}, A & B};
                    OP_OR:   sc_result = {{WIDTH{1'b0}}, A | B};
                    OP_NAND: sc_result = {{WIDTH{1'b0}}, ~(A & B)};
                    OP_XOR:  sc_result = {{WIDTH{1'b0}}, A ^ B};
                    default: sc_result = '0;
                endcase
            end
            CLS_CMP: begin
                case (op)
                    OP_EQ:      sc_result = {{(2*WIDTH-1){1'b0}}, (A == B)};
                    OP_GT:      sc_result = {{(2*WIDTH-1){1'b0}}, ($signed(A) > $signed(B))};
                    OP_LT:      sc_result = {{(2*WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
                    OP_CMP_RSV: sc_result = '0;
                    default:    sc_result = '0;
                endcase
            end
            CLS_SHIFT: begin
                case (op)
                    OP_SRL:  sc_result = {{WIDTH{1'b0}}, srl_v};
                    OP_SLL:  sc_result = {{WIDTH{1'b0}}, sll_v};
                    OP_SRA:  sc_result = {{WIDTH{1'b0}}, sra_v};
                    OP_ROL:  sc_result = {{WIDTH{1'b0}}, rol_wide[2*WIDTH-1:WIDTH]};
                    default: sc_result = '0;
                endcase
            end
            default: sc_result = '0;
        endcase
    end

    seq_muldiv_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk    (CLK),
        .rst    (RST),
        .start  (accept && use_engine),
        .op     (op),
        .a      (A),
        .b      (B),
        .done   (eng_done),
        .result (eng_result)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (use_engine) begin
                            state <= ST_BUSY;
                        end else begin
                            state               <= ST_DONE;
                            result_q            <= sc_result;
                            flags_q[FLAG_CARRY] <= sc_carry;
                            flags_q[FLAG_ZERO]  <= (sc_result == '0);
                            flags_q[FLAG_DIV0]  <= sc_div0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (eng_done) begin
                        state               <= ST_DONE;
                        result_q            <= eng_result;
                        flags_q[FLAG_CARRY] <= 1'b0;
                        flags_q[FLAG_ZERO]  <= (eng_result == '0);
                        flags_q[FLAG_DIV0]  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign IN_READY  = (state == ST_IDLE);
    assign OUT_VALID = (state == ST_DONE);
    assign RESULT    = result_q;
    assign CARRY_OUT = flags_q[FLAG_CARRY];
    assign ZERO_FLAG = flags_q[FLAG_ZERO];
    assign DIV0_FLAG = flags_q[FLAG_DIV0];

endmodule
